hand_rx_fifo: RTL



---
 rtl/hand_rx_fifo.sv | 107 ++++++++++
 1 files changed

// File: rtl/hand_rx_fifo.sv
// Receive side of a 4-phase req/ack handshake feeding a show-ahead FIFO; ack rises 3 edges after req.
// A full FIFO holds the handshake in IDLE, so ack is withheld and the sender stalls.
module hand_rx_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          rx_clk,
  input  logic          reset_n,
  input  logic          req,
  input  logic [DW-1:0] rx_data_in,
  output logic          ack,
  output logic [DW-1:0] rx_data_out,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [AW:0]   fifo_cnt,
  output logic          full
);

  typedef enum logic {IDLE, WAIT_LOW} state_t;

  state_t        r_state;
  logic          r_req_s1;
  logic          r_req_s2;
  logic          r_ack;
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;

  logic          w_full;
  logic          w_push;
  logic          w_pop;

  // Full is judged on the current occupancy, so a same-cycle pop never lets a write through.
  assign w_full = (r_cnt == (AW+1)'(DEPTH));
  assign w_push = (r_state == IDLE) && r_req_s2 && !w_full;
  assign w_pop  = (r_cnt != '0) && rx_ready;

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_s1 <= 1'b0;
      r_req_s2 <= 1'b0;
    end else begin
      r_req_s1 <= req;
      r_req_s2 <= r_req_s1;
    end
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_req_s2 && !w_full) begin
            r_ack   <= 1'b1;
            r_state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!r_req_s2) begin
            r_ack   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Data needs no synchroniser: the sender holds it stable well before req_s2 is seen.
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= rx_data_in;
      r_wptr        <= r_wptr + 1'b1;
    end
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign ack         = r_ack;
  assign rx_valid    = (r_cnt != '0);
  assign rx_data_out = r_mem[r_rptr];
  assign fifo_cnt    = r_cnt;
  assign full        = w_full;

endmodule
